// File: rtl/mult_seq_ctrl_pkg.sv
// rtl/mult_seq_ctrl_pkg.sv - shared constants and state encoding for the sequential multiplier
package mult_pkg;
  localparam int MULT_WIDTH = 32;
  localparam int CNT_W      = 6;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  // The product is negative only for a signed multiply with operands of opposite sign.
  function automatic logic result_neg(input logic sgn, input logic a_msb, input logic b_msb);
    return sgn & (a_msb ^ b_msb);
  endfunction
endpackage

// File: rtl/mult_seq_ctrl_if.sv
// rtl/mult_seq_ctrl_if.sv - request/result bundle between pipeline and multiplier
interface mult_seq_ctrl_if
  import mult_pkg::*;
#(
  parameter int WIDTH = MULT_WIDTH
);
  logic             Start;
  logic             Signed;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             Busy;
  logic             Done;
  logic [WIDTH-1:0] HI;
  logic [WIDTH-1:0] LO;

  modport master (output Start, Signed, A, B, input Busy, Done, HI, LO);
  modport slave  (input Start, Signed, A, B, output Busy, Done, HI, LO);
endinterface

// File: rtl/mult_seq_datapath.sv
// rtl/mult_seq_datapath.sv - multiplicand/product registers, shift-add step and sign fix
module mult_seq_datapath
  import mult_pkg::*;
#(
  parameter int WIDTH = MULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             step,
  input  logic             fix,
  input  logic             sgn,
  input  logic             neg,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);
  logic [WIDTH-1:0]   mcand;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   a_mag;
  logic [WIDTH-1:0]   b_mag;
  logic [WIDTH:0]     sum;
  logic [2*WIDTH-1:0] fixed;

  // Magnitudes are treated as unsigned, so the most negative value maps onto itself correctly.
  always_comb begin
    a_mag = (sgn && a[WIDTH-1]) ? -a : a;
    b_mag = (sgn && b[WIDTH-1]) ? -b : b;
    sum   = {1'b0, prod[2*WIDTH-1:WIDTH]} + {1'b0, (prod[0] ? mcand : {WIDTH{1'b0}})};
    fixed = neg ? -prod : prod;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand <= '0;
      prod  <= '0;
      hi    <= '0;
      lo    <= '0;
    end else if (load) begin
      mcand <= a_mag;
      prod  <= {{WIDTH{1'b0}}, b_mag};
    end else if (step) begin
      prod <= {sum, prod[WIDTH-1:1]};
    end else if (fix) begin
      prod <= fixed;
      hi   <= fixed[2*WIDTH-1:WIDTH];
      lo   <= fixed[WIDTH-1:0];
    end
  end
endmodule

// File: rtl/mult_seq_ctrl.sv
// rtl/mult_seq_ctrl.sv - FSM and iteration counter sequencing the shift-add multiplier
module mult_seq_ctrl
  import mult_pkg::*;
#(
  parameter int WIDTH = MULT_WIDTH,
  parameter int CNT_W = mult_pkg::CNT_W
) (
  input logic            CLK,
  input logic            nRST,
  mult_seq_ctrl_if.slave bus
);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             neg;
  logic             busy;
  logic             done;
  logic             load;
  logic             step;
  logic             fix;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  always_comb begin
    load = bus.Start && (state == S_IDLE || state == S_DONE);
    step = (state == S_CALC);
    fix  = (state == S_FIX);
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state <= S_IDLE;
      cnt   <= '0;
      neg   <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE, S_DONE: begin
          if (bus.Start) begin
            state <= S_CALC;
            cnt   <= '0;
            neg   <= result_neg(bus.Signed, bus.A[WIDTH-1], bus.B[WIDTH-1]);
            busy  <= 1'b1;
          end else begin
            state <= S_IDLE;
          end
        end
        S_CALC: begin
          cnt <= cnt + CNT_W'(1);
          if (cnt == LAST) state <= S_FIX;
        end
        S_FIX: begin
          state <= S_DONE;
          busy  <= 1'b0;
          done  <= 1'b1;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  mult_seq_datapath #(.WIDTH(WIDTH)) u_dp (
    .clk   (CLK),
    .rst_n (nRST),
    .load  (load),
    .step  (step),
    .fix   (fix),
    .sgn   (bus.Signed),
    .neg   (neg),
    .a     (bus.A),
    .b     (bus.B),
    .hi    (hi),
    .lo    (lo)
  );

  assign bus.Busy = busy;
  assign bus.Done = done;
  assign bus.HI   = hi;
  assign bus.LO   = lo;
endmodule

// File: doc/mult_seq_ctrl.md
Name: mult_seq_ctrl

Overview:
- Sequential shift-add controller for the MIPS multiplier (MULT/MULTU).
- Owns the FSM, the iteration counter, and the multiplicand/product registers. Sequences one add-and-shift per clock, then applies sign correction.
- Drives the HI/LO results back to the register file and raises a Busy stall to the pipeline while a multiply is in flight.

Parameters:
- WIDTH, 32, operand width in bits; product is 2*WIDTH bits.
- CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- CLK  input  1  system clock, rising edge.
- nRST  input  1  asynchronous active-low reset.
- Start  input  1  one-cycle request to begin a multiply; sampled only in IDLE or DONE.
- Signed  input  1  1 = MULT (two's complement), 0 = MULTU; sampled with Start.
- A  input  WIDTH  multiplicand; sampled with Start.
- B  input  WIDTH  multiplier; sampled with Start.
- Busy  output  1  high in CALC and FIX; pipeline stall request.
- Done  output  1  one-cycle pulse; HI/LO are valid in this cycle.
- HI  output  WIDTH  upper half of product.
- LO  output  WIDTH  lower half of product.

Behaviour:
- Reset (async, nRST=0): state=IDLE, counter=0, product=0, neg flag=0. Busy=0, Done=0, HI=0, LO=0. Takes effect immediately, including mid-CALC/FIX; the in-flight operation is discarded and no Done is issued.
- States: IDLE, CALC, FIX, DONE; Moore outputs.
- IDLE -> CALC on Start=1 (edge E0). At E0:
  - Mcand <= |A| if Signed, else A.
  - P[2W-1:W] <= 0; P[W-1:0] <= |B| if Signed, else B.
  - neg <= Signed & (A[W-1]^B[W-1]).
  - cnt <= 0.
- Magnitude rule: |x| = two's-complement negate when x[W-1]=1, result interpreted as unsigned. 0x80000000 therefore yields 0x80000000 unsigned, which is correct.
- CALC, each edge:
  - sum = {1'b0, P[2W-1:W]} + (P[0] ? Mcand : 0), computed at W+1 bits so the carry is kept.
  - P <= {sum, P[W-1:1]}.
  - cnt <= cnt+1.
  - After WIDTH iterations (cnt == WIDTH-1 at the edge): -> FIX.
- FIX, one edge: P <= neg ? (~P + 1) : P; -> DONE.
- DONE:
  - Done=1 for exactly one cycle; {HI,LO} = P.
  - Next edge: -> CALC if Start=1 (back-to-back accepted, same load rules as IDLE), else -> IDLE.
- HI/LO hold their last value in IDLE until the next FIX completes.
- Latency: Start sampled at E0; Done high in the cycle after edge E0+WIDTH+1, i.e. 33 edges for WIDTH=32. Busy high from after E0 through the FIX cycle.
- Start while Busy=1: ignored, no queuing; the requester must hold the instruction stalled.
- A, B, Signed may change freely after E0; only the latched copies are used.
- Zero operands: no special case; runs the full WIDTH iterations.

Decomposition:
- Shared package mult_pkg holds:
  - state encoding constants S_IDLE=2'd0, S_CALC=2'd1, S_FIX=2'd2, S_DONE=2'd3;
  - MULT_WIDTH=32;
  - CNT_W=6.
- One sub-module, mult_seq_datapath:
  - contains the Mcand/P registers, the W+1-bit conditional adder and the final negator;
  - control inputs load, step, fix and the neg flag come from the FSM in mult_seq_ctrl.
- The counter and FSM stay in the top.

Test Plan:
- Unsigned: Start, Signed=0, A=0xFFFFFFFF, B=0xFFFFFFFF -> Done on edge 33 after Start; HI=0xFFFFFFFE, LO=0x00000001; Busy high for exactly 32+1 cycles.
- Signed negative: Signed=1, A=0xFFFFFFFD (-3), B=0x00000007 -> HI=0xFFFFFFFF, LO=0xFFFFFFEB (-21).
- Signed boundary: Signed=1, A=0x80000000, B=0x80000000 -> HI=0x40000000, LO=0x00000000. Same operands with Signed=0 -> HI=0x40000000, LO=0x00000000.
- Start ignored while busy, then back-to-back:
  - Start pulsed mid-CALC has no effect; result unchanged.
  - Start in the DONE cycle with A=5, B=6, Signed=0 -> second Done 33 edges later, HI=0, LO=30; no IDLE cycle in between.
- Reset mid-op: deassert nRST at iteration 10 -> Busy=0, Done=0, HI=LO=0 immediately. After release, no Done appears until a new Start.
- Operand change after Start: A=2, B=3, Signed=1; A/B toggled randomly during CALC -> HI=0, LO=6.
